regfile_param: RTL and testbench

Parametrised multi-read-port register file for the single-cycle CPU datapath, replacing the fixed 32x32, two-read-port register bank. It adds a configurable number of read ports and a sequential initialisation engine that loads each register with its own index after reset or on request. It also adds hardwired-zero register 0, a write-drop indication and optional write-to-read forwarding. It sits between instruction decode (read addresses) and the write-back mux (write port).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_init_fsm.sv | 65 ++++++
 rtl/regfile_param.sv | 75 +++++++
 tb/tb_regfile_param.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and sizing helper for the parametrised register file
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int depth_f(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_init_fsm.sv
// regfile_init_fsm: INIT/RUN sequencer that walks every register index after reset or init_req
module regfile_init_fsm
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              init_req,
    output logic              ready,
    output logic              wr_drop,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data
);

    localparam int DEPTH = depth_f(ADDR_W);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_ready;
    logic              r_drop;

    // State, counter and registered status flags; a write requested while not ready pulses wr_drop
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state <= INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= wr_en & ~r_ready;
            case (r_state)
                INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (init_req) begin
                        r_state <= INIT;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= INIT;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign wr_drop   = r_drop;
    assign init_we   = (r_state == INIT);
    assign init_addr = r_cnt;
    assign init_data = DATA_W'(r_cnt);

endmodule

// File: rtl/regfile_param.sv
// regfile_param: multi-read-port register file with index initialisation, hardwired zero register,
// write-drop flag and optional same-cycle write forwarding (enabled by REGFILE_BYPASS_EN)
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int NUM_DBG = 4
) (
    input  logic                     clock_in,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     init_req,
    output logic                     ready,
    output logic                     wr_drop,
    output logic [NUM_DBG*8-1:0]     dbg_data
);

    localparam int DEPTH = depth_f(ADDR_W);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_init_we;
    logic [ADDR_W-1:0] w_init_addr;
    logic [DATA_W-1:0] w_init_data;
    logic              w_run_we;

    regfile_init_fsm #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fsm (
        .clock_in  (clock_in),
        .reset     (reset),
        .wr_en     (wr_en),
        .init_req  (init_req),
        .ready     (ready),
        .wr_drop   (wr_drop),
        .init_we   (w_init_we),
        .init_addr (w_init_addr),
        .init_data (w_init_data)
    );

    assign w_run_we = ready & wr_en & (wr_addr != '0);

    // Array storage: init engine owns the write port in INIT, the datapath owns it in RUN
    always_ff @(posedge clock_in) begin
        if (w_init_we)
            r_mem[w_init_addr] <= w_init_data;
        else if (w_run_we)
            r_mem[wr_addr] <= wr_data;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_hit;
        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];
        assign w_hit  = BYPASS & w_run_we & (w_addr == wr_addr);
        assign rd_data[k*DATA_W +: DATA_W] = (!ready || w_addr == '0) ? '0 :
                                             w_hit ? wr_data : r_mem[w_addr];
    end

    for (genvar j = 0; j < NUM_DBG; j++) begin : g_dbg
        assign dbg_data[j*8 +: 8] = ready ? r_mem[j+1][7:0] : 8'h00;
    end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed self-checking bench for regfile_param (default parameters)
module tb_regfile_param;

    logic        clock_in = 1'b0;
    logic        reset    = 1'b0;
    logic [9:0]  rd_addr  = '0;
    logic [63:0] rd_data;
    logic        wr_en    = 1'b0;
    logic [4:0]  wr_addr  = '0;
    logic [31:0] wr_data  = '0;
    logic        init_req = 1'b0;
    logic        ready;
    logic        wr_drop;
    logic [31:0] dbg_data;

    int n_cmp = 0;
    int n_err = 0;

    regfile_param dut (
        .clock_in (clock_in),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .init_req (init_req),
        .ready    (ready),
        .wr_drop  (wr_drop),
        .dbg_data (dbg_data)
    );

    always #5 clock_in = ~clock_in;

    task automatic tick;
        @(posedge clock_in);
        #1;
    endtask

    task automatic test_reset;
        int early;
        reset = 1'b1;
        #12;
        n_cmp++;
        if (ready !== 1'b0 || wr_drop !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: ready=%b wr_drop=%b, need 0 0", ready, wr_drop);
        end
        rd_addr = {5'd31, 5'd3};
        #1;
        n_cmp++;
        if (rd_data !== 64'd0 || dbg_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_reads: rd=%h dbg=%h, need 0 0", rd_data, dbg_data);
        end
        @(posedge clock_in);
        #1;
        reset = 1'b0;
        early = 0;
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (ready !== 1'b0) early++;
        end
        n_cmp++;
        if (early !== 0) begin
            n_err++;
            $display("FAIL init_early_ready: high on %0d of edges 1..31, need 0", early);
        end
        tick();
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL init_ready_edge32: ready=%b, need 1", ready);
        end
        n_cmp++;
        if (rd_data !== {32'd31, 32'd3}) begin
            n_err++;
            $display("FAIL init_reads: rd=%h, need %h", rd_data, {32'd31, 32'd3});
        end
        n_cmp++;
        if (dbg_data !== 32'h04030201) begin
            n_err++;
            $display("FAIL init_dbg: dbg=%h, need 04030201", dbg_data);
        end
    endtask

    task automatic test_write;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0;
        rd_addr = {5'd4, 5'd5};
        #1;
        n_cmp++;
        if (rd_data !== {32'd4, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL write_reg5: rd=%h, need %h", rd_data, {32'd4, 32'hDEADBEEF});
        end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        tick();
        wr_en = 1'b0;
        rd_addr = {5'd0, 5'd0};
        #1;
        n_cmp++;
        if (rd_data !== 64'd0) begin
            n_err++;
            $display("FAIL write_reg0: rd=%h, need 0", rd_data);
        end
        n_cmp++;
        if (wr_drop !== 1'b0) begin
            n_err++;
            $display("FAIL write_reg0_drop: wr_drop=%b, need 0", wr_drop);
        end
    endtask

    task automatic test_same_cycle;
        logic [31:0] exp_now;
`ifdef REGFILE_BYPASS_EN
        exp_now = 32'hA5A5;
`else
        exp_now = 32'd7;
`endif
        rd_addr = {5'd7, 5'd7};
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5;
        #1;
        n_cmp++;
        if (rd_data !== {exp_now, exp_now}) begin
            n_err++;
            $display("FAIL same_cycle_read: rd=%h, need %h", rd_data, {exp_now, exp_now});
        end
        tick();
        wr_en = 1'b0;
        #1;
        n_cmp++;
        if (rd_data !== {32'hA5A5, 32'hA5A5}) begin
            n_err++;
            $display("FAIL same_cycle_next: rd=%h, need %h", rd_data, {32'hA5A5, 32'hA5A5});
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_addr = 5'(10 + i); wr_data = 32'h1000 + i;
            tick();
        end
        wr_en = 1'b0;
        rd_addr = {5'd12, 5'd10};
        #1;
        n_cmp++;
        if (rd_data !== {32'h1002, 32'h1000}) begin
            n_err++;
            $display("FAIL b2b_10_12: rd=%h, need %h", rd_data, {32'h1002, 32'h1000});
        end
        rd_addr = {5'd1, 5'd11};
        #1;
        n_cmp++;
        if (rd_data !== {32'd1, 32'h1001}) begin
            n_err++;
            $display("FAIL b2b_11_1: rd=%h, need %h", rd_data, {32'd1, 32'h1001});
        end
    endtask

    task automatic test_drop_in_init;
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL drop_ready_fall: ready=%b, need 0", ready);
        end
        for (int i = 1; i <= 9; i++) tick();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hBAD0BAD0;
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if (wr_drop !== 1'b1) begin
            n_err++;
            $display("FAIL drop_pulse: wr_drop=%b, need 1", wr_drop);
        end
        tick();
        n_cmp++;
        if (wr_drop !== 1'b0) begin
            n_err++;
            $display("FAIL drop_one_cycle: wr_drop=%b, need 0", wr_drop);
        end
        for (int i = 12; i <= 32; i++) tick();
        rd_addr = {5'd5, 5'd9};
        #1;
        n_cmp++;
        if (ready !== 1'b1 || rd_data !== {32'd5, 32'd9}) begin
            n_err++;
            $display("FAIL drop_reg9: ready=%b rd=%h, need 1 %h", ready, rd_data, {32'd5, 32'd9});
        end
    endtask

    task automatic test_reinit_ignored;
        int low;
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hFF;
        tick();
        wr_en = 1'b0;
        rd_addr = {5'd0, 5'd2};
        #1;
        n_cmp++;
        if (rd_data !== {32'd0, 32'hFF}) begin
            n_err++;
            $display("FAIL reinit_pre: rd=%h, need %h", rd_data, {32'd0, 32'hFF});
        end
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        low = (ready === 1'b0) ? 1 : 0;
        for (int i = 1; i <= 31; i++) begin
            init_req = (i == 5);
            tick();
            if (ready === 1'b0) low++;
        end
        init_req = 1'b0;
        n_cmp++;
        if (low !== 32) begin
            n_err++;
            $display("FAIL reinit_low_span: low for %0d samples before edge 32, need 32", low);
        end
        tick();
        n_cmp++;
        if (ready !== 1'b1 || rd_data !== {32'd0, 32'd2}) begin
            n_err++;
            $display("FAIL reinit_done: ready=%b rd=%h, need 1 %h", ready, rd_data, {32'd0, 32'd2});
        end
    endtask

    task automatic test_reset_mid_init;
        int early;
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        for (int i = 1; i <= 20; i++) tick();
        reset = 1'b1;
        rd_addr = {5'd20, 5'd3};
        #1;
        n_cmp++;
        if (ready !== 1'b0 || rd_data !== 64'd0) begin
            n_err++;
            $display("FAIL midreset_state: ready=%b rd=%h, need 0 0", ready, rd_data);
        end
        tick();
        reset = 1'b0;
        early = 0;
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (ready !== 1'b0) early++;
        end
        n_cmp++;
        if (early !== 0) begin
            n_err++;
            $display("FAIL midreset_early: high on %0d of edges 1..31, need 0", early);
        end
        tick();
        rd_addr = {5'd31, 5'd20};
        #1;
        n_cmp++;
        if (ready !== 1'b1 || rd_data !== {32'd31, 32'd20}) begin
            n_err++;
            $display("FAIL midreset_done: ready=%b rd=%h, need 1 %h", ready, rd_data, {32'd31, 32'd20});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_same_cycle();
        test_back_to_back();
        test_drop_in_init();
        test_reinit_ignored();
        test_reset_mid_init();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
